// File: rtl/axi_lite_cmd_master.sv
// ----------------------------------------------------------------------------
// axi_lite_cmd_master
//
// Purpose:
//   Command-driven AXI-Lite-style master placed in front of the USB host
//   controller's register/memory slave. Firmware pushes single read or write
//   commands into a small FIFO; each command is turned into the slave's write
//   or read channel handshakes and one response (read data + error flags) is
//   returned per command. Exactly one transaction is in flight at a time.
//
// Optional feature:
//   `define AXI_CMD_TIMEOUT_EN to add a handshake timeout. A stalled channel is
//   abandoned after TIMEOUT_CYCLES cycles and the response reports
//   rsp_err=1, rsp_timeout=1. Without the macro the FSM waits indefinitely
//   and rsp_timeout is tied to 0.
//
// Ports:
//   Clk_axi, Rst (async, active-low)
//   Command in : cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_wdata, cmd_strb
//   Response   : rsp_valid/rsp_ready, rsp_rdata, rsp_err, rsp_timeout
//   Write chan : Write_Address_axi, Write_Data_axi, Write_Strobe, Write_Valid,
//                W_Prot, Write_Ready, W_Error
//   Read chan  : Read_Address_axi, R_Valid_Address, R_Prot, R_Ready_Address,
//                Valid_Data_R, Read_Ready, Read_Data_axi, R_Error
// ----------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic              Clk_axi,
    input  logic              Rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] Write_Address_axi,
    output logic [DATA_W-1:0] Write_Data_axi,
    output logic [3:0]        Write_Strobe,
    output logic              Write_Valid,
    output logic [2:0]        W_Prot,
    input  logic              Write_Ready,
    input  logic              W_Error,
    output logic [ADDR_W-1:0] Read_Address_axi,
    output logic              R_Valid_Address,
    output logic [2:0]        R_Prot,
    input  logic              R_Ready_Address,
    input  logic              Valid_Data_R,
    output logic              Read_Ready,
    input  logic [DATA_W-1:0] Read_Data_axi,
    input  logic              R_Error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

    // Elaboration-time parameter sanity check.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("axi_lite_cmd_master: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          strb_q, strb_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    // Command storage: data only, no reset needed.
    logic                mem_write_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_q  [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_wdata_q [FIFO_DEPTH];
    logic [3:0]          mem_strb_q  [FIFO_DEPTH];

    logic                fifo_full, fifo_empty, push, pop;
    logic [PTR_W-2:0]    rd_idx;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign cmd_ready  = !fifo_full;
    // Refused when full even if a pop happens in the same cycle.
    assign push       = cmd_valid && !fifo_full;
    assign rd_idx     = rd_ptr_q[PTR_W-2:0];

`ifdef AXI_CMD_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_expire;
    // Counter value N means the channel has been waiting N+1 cycles by the
    // end of this cycle, so the state is left after exactly TIMEOUT_CYCLES.
    assign tmo_expire = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        pop           = 1'b0;
        case (state_q)
            // rsp_valid is only ever high in RESP, so IDLE may always pop.
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    addr_d  = mem_addr_q[rd_idx];
                    wdata_d = mem_wdata_q[rd_idx];
                    strb_d  = mem_strb_q[rd_idx];
                    state_d = mem_write_q[rd_idx] ? WR_REQ : RD_ADDR;
                end
            end
            WR_REQ: begin
                if (Write_Ready) begin
                    rsp_err_d     = W_Error;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end
`ifdef AXI_CMD_TIMEOUT_EN
                else if (tmo_expire) begin
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
`endif
            end
            RD_ADDR: begin
                if (R_Ready_Address) begin
                    state_d = RD_DATA;
                end
`ifdef AXI_CMD_TIMEOUT_EN
                else if (tmo_expire) begin
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
`endif
            end
            RD_DATA: begin
                if (Valid_Data_R) begin
                    rsp_rdata_d   = Read_Data_axi;
                    rsp_err_d     = R_Error;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end
`ifdef AXI_CMD_TIMEOUT_EN
                else if (tmo_expire) begin
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

`ifdef AXI_CMD_TIMEOUT_EN
    // Restarts from zero on entry to any waiting state, including RD_ADDR->RD_DATA.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == WR_REQ || state_q == RD_ADDR || state_q == RD_DATA) &&
            state_d == state_q) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge Clk_axi or negedge Rst) begin
        if (!Rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    always_ff @(posedge Clk_axi or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_ff @(posedge Clk_axi) begin
        if (push) begin
            mem_write_q[wr_ptr_q[PTR_W-2:0]] <= cmd_write;
            mem_addr_q[wr_ptr_q[PTR_W-2:0]]  <= cmd_addr;
            mem_wdata_q[wr_ptr_q[PTR_W-2:0]] <= cmd_wdata;
            mem_strb_q[wr_ptr_q[PTR_W-2:0]]  <= cmd_strb;
        end
    end

    assign Write_Valid       = (state_q == WR_REQ);
    assign R_Valid_Address   = (state_q == RD_ADDR);
    assign Read_Ready        = (state_q == RD_DATA);
    assign rsp_valid         = (state_q == RESP);
    assign Write_Address_axi = addr_q;
    assign Read_Address_axi  = addr_q;
    assign Write_Data_axi    = wdata_q;
    assign Write_Strobe      = strb_q;
    assign W_Prot            = PROT;
    assign R_Prot            = PROT;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_err           = rsp_err_q;
`ifdef AXI_CMD_TIMEOUT_EN
    assign rsp_timeout       = rsp_timeout_q;
`else
    assign rsp_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_cmd_master
//
// Directed bench for axi_lite_cmd_master: single write, single read, FIFO fill
// with a stalled slave, response back-pressure, reset mid-transaction and,
// when AXI_CMD_TIMEOUT_EN is defined, the handshake timeout.
// ----------------------------------------------------------------------------
module tb_axi_lite_cmd_master;

    localparam int         ADDR_W = 32;
    localparam int         DATA_W = 32;
    localparam logic [2:0] PROT   = 3'b101;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic              wr_valid, wr_ready, wr_err;
    logic [2:0]        w_prot, r_prot;
    logic              rd_addr_valid, rd_addr_ready, rd_data_valid, rd_ready, rd_err;

    int checks   = 0;
    int failures = 0;

    axi_lite_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .PROT(PROT), .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk_axi(clk), .Rst(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .Write_Address_axi(wr_addr), .Write_Data_axi(wr_data), .Write_Strobe(wr_strb),
        .Write_Valid(wr_valid), .W_Prot(w_prot), .Write_Ready(wr_ready), .W_Error(wr_err),
        .Read_Address_axi(rd_addr), .R_Valid_Address(rd_addr_valid), .R_Prot(r_prot),
        .R_Ready_Address(rd_addr_ready), .Valid_Data_R(rd_data_valid), .Read_Ready(rd_ready),
        .Read_Data_axi(rd_data), .R_Error(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
    endtask

    // Waits (bounded) for the next request, completes it with zero-wait
    // handshakes and checks and consumes the response.
    task automatic serve_one(input string tag, input bit is_wr, input logic [31:0] a,
                             input logic [31:0] rdat, input bit err);
        int n;
        n = 0;
        while (!wr_valid && !rd_addr_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_vld"}, is_wr ? wr_valid : rd_addr_valid, 1);
        check({tag, "_addr"}, is_wr ? wr_addr : rd_addr, a);
        if (is_wr) begin
            wr_ready = 1'b1; wr_err = err;
            step();
            wr_ready = 1'b0; wr_err = 1'b0;
        end else begin
            rd_addr_ready = 1'b1;
            step();
            rd_addr_ready = 1'b0;
            check({tag, "_rready"}, rd_ready, 1);
            rd_data_valid = 1'b1; rd_data = rdat; rd_err = err;
            step();
            rd_data_valid = 1'b0; rd_err = 1'b0;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_rdata"}, rsp_rdata, is_wr ? 32'h0 : rdat);
        check({tag, "_rsp_err"}, rsp_err, err);
        check({tag, "_rsp_tmo"}, rsp_timeout, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int cnt;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        rsp_ready = 0; wr_ready = 0; wr_err = 0; rd_addr_ready = 0;
        rd_data_valid = 0; rd_data = 0; rd_err = 0;

        // ---- reset state ----
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wvalid", wr_valid, 0);
        check("rst_arvalid", rd_addr_valid, 0);
        check("rst_rready", rd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_waddr", wr_addr, 0);
        check("rst_wprot", w_prot, PROT);
        check("rst_rprot", r_prot, PROT);
        rst_n = 1'b1;
        step();

        // ---- single write, Write_Ready 3 cycles after Write_Valid ----
        drive_cmd(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF);
        check("wr_push_rdy", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("wr_lat1_low", wr_valid, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_vld_c%0d", i), wr_valid, 1);
            check($sformatf("wr_addr_c%0d", i), wr_addr, 32'h0000_0010);
            check($sformatf("wr_data_c%0d", i), wr_data, 32'hA5A5_1234);
            check($sformatf("wr_strb_c%0d", i), wr_strb, 4'hF);
            check($sformatf("wr_no_rd_c%0d", i), rd_addr_valid, 0);
            if (i == 3) begin
                wr_ready = 1'b1; wr_err = 1'b0;
            end
            step();
        end
        wr_ready = 1'b0;
        check("wr_vld_drop", wr_valid, 0);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_tmo", rsp_timeout, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wr_rsp_done", rsp_valid, 0);

        // ---- single read; early Valid_Data_R in RD_ADDR must be ignored ----
        drive_cmd(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        step();
        cmd_valid = 1'b0;
        step();
        check("rd_arvalid_c0", rd_addr_valid, 1);
        check("rd_araddr", rd_addr, 32'h0000_0044);
        check("rd_rready_c0", rd_ready, 0);
        rd_data_valid = 1'b1; rd_data = 32'h1111_1111; rd_err = 1'b0;
        step();
        rd_data_valid = 1'b0;
        check("rd_arvalid_c1", rd_addr_valid, 1);
        check("rd_rready_c1", rd_ready, 0);
        rd_addr_ready = 1'b1;
        step();
        rd_addr_ready = 1'b0;
        check("rd_arvalid_drop", rd_addr_valid, 0);
        check("rd_rready_c2", rd_ready, 1);
        step();
        check("rd_rready_c3", rd_ready, 1);
        rd_data_valid = 1'b1; rd_data = 32'hDEAD_BEEF; rd_err = 1'b1;
        step();
        rd_data_valid = 1'b0; rd_err = 1'b0;
        check("rd_rready_drop", rd_ready, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_rsp_err", rsp_err, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---- fill the FIFO behind a stalled write ----
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_rdy_%0d", i), cmd_ready, 1);
            drive_cmd(i[0] == 1'b0, 32'h100 + 32'(4 * i), 32'h1 + 32'(i), 4'hF);
            step();
        end
        drive_cmd(1'b0, 32'h114, 32'h0, 4'h0);
        check("fill_full", cmd_ready, 0);
        check("fill_c0_wvld", wr_valid, 1);
        check("fill_c0_addr", wr_addr, 32'h100);
        repeat (3) step();
        check("fill_full_hold", cmd_ready, 0);
        wr_ready = 1'b1; wr_err = 1'b1;
        step();
        wr_ready = 1'b0; wr_err = 1'b0;
        check("c0_rsp_valid", rsp_valid, 1);
        check("c0_rsp_err", rsp_err, 1);
        check("c0_rsp_rdata", rsp_rdata, 0);

        // ---- response back-pressure for 10 cycles ----
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wr_valid || rd_addr_valid || !rsp_valid || rsp_err !== 1'b1 ||
                rsp_rdata !== 32'h0 || cmd_ready)
                ok = 1'b0;
        end
        check("bp_hold_stable", ok, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        // IDLE cycle: pop happens this cycle but the full FIFO still refuses c5.
        check("pop_cycle_full", cmd_ready, 0);
        check("pop_cycle_rspv", rsp_valid, 0);
        step();
        check("after_pop_rdy", cmd_ready, 1);
        check("c1_arvalid", rd_addr_valid, 1);
        step();
        cmd_valid = 1'b0;
        serve_one("c1", 1'b0, 32'h104, 32'h0000_1104, 1'b0);
        serve_one("c2", 1'b1, 32'h108, 32'h0, 1'b0);
        serve_one("c3", 1'b0, 32'h10C, 32'h0000_110C, 1'b1);
        serve_one("c4", 1'b1, 32'h110, 32'h0, 1'b0);
        serve_one("c5", 1'b0, 32'h114, 32'h0000_1114, 1'b0);
        repeat (3) step();
        check("drain_idle", wr_valid | rd_addr_valid, 0);
        check("drain_rdy", cmd_ready, 1);

        // ---- reset while Write_Valid is high, with a second command queued ----
        drive_cmd(1'b1, 32'h200, 32'h5555_AAAA, 4'h3);
        step();
        drive_cmd(1'b0, 32'h204, 32'h0, 4'h0);
        step();
        cmd_valid = 1'b0;
        check("mrst_pre_wvld", wr_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_wvld", wr_valid, 0);
        check("mrst_waddr", wr_addr, 0);
        check("mrst_wdata", wr_data, 0);
        check("mrst_rspv", rsp_valid, 0);
        check("mrst_cmd_rdy", cmd_ready, 1);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("mrst_fifo_empty", wr_valid | rd_addr_valid | rsp_valid, 0);
        check("mrst_rdy_after", cmd_ready, 1);
        drive_cmd(1'b0, 32'h300, 32'h0, 4'h0);
        step();
        cmd_valid = 1'b0;
        serve_one("post_rst", 1'b0, 32'h300, 32'hCAFE_0300, 1'b0);

`ifdef AXI_CMD_TIMEOUT_EN
        // ---- timeout: slave never answers the write ----
        drive_cmd(1'b1, 32'h400, 32'h1234_5678, 4'hF);
        step();
        cmd_valid = 1'b0;
        step();
        cnt = 0;
        while (wr_valid && cnt < 40) begin
            cnt++;
            step();
        end
        check("tmo_wvld_cycles", cnt, 16);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_tmo", rsp_timeout, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`else
        cnt = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
